id_ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-delivery stage that drives the ALU's input interface: rsdata, rtdataOrextimm and ALUctrl. It registers decoded instruction fields and decodes ALUOp/funct into the 4-bit ALU control code. It resolves MEM/WB forwarding and selects register or immediate for the second operand. It also detects load-use hazards, inserts bubbles, and honours pipeline stall and flush.

---
 rtl/id_ex_operand_stage.sv | 194 +++++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: decodes the ALU control code, forwards operands from MEM/WB and inserts bubbles on load-use hazards.
// Latency: ID fields registered in one cycle. Forwarded operands and load_use_hazard are combinational in the EX cycle.
// Backpressure: stall holds all EX registers; flush or a load-use hazard loads a bubble; flush takes priority over stall.
module id_ex_operand_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rsdata,
    input  logic [31:0] id_rtdata,
    input  logic [31:0] id_signimm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [1:0]  id_aluop,
    input  logic [5:0]  id_funct,
    input  logic        id_alusrc,
    input  logic        id_regdst,
    input  logic        id_regwrite,
    input  logic        id_memtoreg,
    input  logic        id_memwrite,
    input  logic        id_branch,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    output logic [31:0] rsdata,
    output logic [31:0] rtdataOrextimm,
    output logic [3:0]  ALUctrl,
    output logic [31:0] ex_storedata,
    output logic [4:0]  ex_writereg,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memtoreg,
    output logic        ex_memwrite,
    output logic        ex_branch,
    output logic        ex_illegal,
    output logic        load_use_hazard
);

    // ALU control encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // EX-stage registers
    logic        r_valid;
    logic        r_regwrite;
    logic        r_memtoreg;
    logic        r_memwrite;
    logic        r_branch;
    logic        r_illegal;
    logic        r_alusrc;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_writereg;
    logic [31:0] r_rsdata;
    logic [31:0] r_rtdata;
    logic [31:0] r_signimm;
    logic [3:0]  r_aluctrl;

    // Decode and control wires
    logic [3:0]  w_aluctrl;
    logic        w_illegal;
    logic [4:0]  w_writereg;
    logic        w_load_use;
    logic        w_load_en;
    logic        w_load_bubble;
    logic [31:0] w_fwd_rs;
    logic [31:0] w_fwd_rt;

    // Decode ALUOp/funct into the ALU control code; unknown R-type funct is flagged illegal
    always_comb begin
        w_aluctrl = ALU_ADD;
        w_illegal = 1'b0;
        case (id_aluop)
            2'b00: w_aluctrl = ALU_ADD;
            2'b01: w_aluctrl = ALU_SUB;
            2'b11: w_aluctrl = ALU_OR;
            default: begin
                case (id_funct)
                    6'b100000: w_aluctrl = ALU_ADD;
                    6'b100010: w_aluctrl = ALU_SUB;
                    6'b100100: w_aluctrl = ALU_AND;
                    6'b100101: w_aluctrl = ALU_OR;
                    6'b101010: w_aluctrl = ALU_SLT;
                    default: begin
                        w_aluctrl = ALU_ADD;
                        w_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign w_writereg = id_regdst ? id_rd : id_rt;

    // A load in EX whose destination is read by the instruction in ID cannot be forwarded in time
    assign w_load_use = r_valid & r_memtoreg & (r_writereg != 5'd0) & id_valid &
                        ((r_writereg == id_rs) | (r_writereg == id_rt));

    // Flush always loads; otherwise stall freezes, and an unstalled hazard loads a bubble
    assign w_load_en     = flush | ~stall;
    assign w_load_bubble = flush | w_load_use;

    // EX register update: bubble on reset/flush/hazard, hold on stall, otherwise capture ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
            r_branch   <= 1'b0;
            r_illegal  <= 1'b0;
            r_alusrc   <= 1'b0;
            r_rs       <= 5'd0;
            r_rt       <= 5'd0;
            r_writereg <= 5'd0;
            r_rsdata   <= 32'd0;
            r_rtdata   <= 32'd0;
            r_signimm  <= 32'd0;
            r_aluctrl  <= ALU_ADD;
        end else if (w_load_en) begin
            if (w_load_bubble) begin
                r_valid    <= 1'b0;
                r_regwrite <= 1'b0;
                r_memtoreg <= 1'b0;
                r_memwrite <= 1'b0;
                r_branch   <= 1'b0;
                r_illegal  <= 1'b0;
                r_alusrc   <= 1'b0;
                r_rs       <= 5'd0;
                r_rt       <= 5'd0;
                r_writereg <= 5'd0;
                r_rsdata   <= 32'd0;
                r_rtdata   <= 32'd0;
                r_signimm  <= 32'd0;
                r_aluctrl  <= ALU_ADD;
            end else begin
                r_valid    <= id_valid;
                r_regwrite <= id_regwrite & ~w_illegal;
                r_memtoreg <= id_memtoreg;
                r_memwrite <= id_memwrite & ~w_illegal;
                r_branch   <= id_branch;
                r_illegal  <= w_illegal;
                r_alusrc   <= id_alusrc;
                r_rs       <= id_rs;
                r_rt       <= id_rt;
                r_writereg <= w_writereg;
                r_rsdata   <= id_rsdata;
                r_rtdata   <= id_rtdata;
                r_signimm  <= id_signimm;
                r_aluctrl  <= w_aluctrl;
            end
        end
    end

    // Operand forwarding: MEM beats WB; register 0 is never forwarded
    always_comb begin
        w_fwd_rs = r_rsdata;
        if (mem_regwrite && (mem_rd == r_rs) && (r_rs != 5'd0))
            w_fwd_rs = mem_result;
        else if (wb_regwrite && (wb_rd == r_rs) && (r_rs != 5'd0))
            w_fwd_rs = wb_result;
    end

    // Same forwarding selection for the rt operand
    always_comb begin
        w_fwd_rt = r_rtdata;
        if (mem_regwrite && (mem_rd == r_rt) && (r_rt != 5'd0))
            w_fwd_rt = mem_result;
        else if (wb_regwrite && (wb_rd == r_rt) && (r_rt != 5'd0))
            w_fwd_rt = wb_result;
    end

    assign rsdata          = w_fwd_rs;
    assign rtdataOrextimm  = r_alusrc ? r_signimm : w_fwd_rt;
    assign ex_storedata    = w_fwd_rt;
    assign ALUctrl         = r_aluctrl;
    assign ex_writereg     = r_writereg;
    assign ex_valid        = r_valid;
    assign ex_regwrite     = r_regwrite;
    assign ex_memtoreg     = r_memtoreg;
    assign ex_memwrite     = r_memwrite;
    assign ex_branch       = r_branch;
    assign ex_illegal      = r_illegal;
    assign load_use_hazard = w_load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: stimulus queues expected values, a negedge monitor compares them.
// Expectations are queued at posedge+1 and consumed at the following negedge.
// Stall, flush and hazard sequences are driven directly by the stimulus process.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid;
    logic [31:0] id_rsdata, id_rtdata, id_signimm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic        id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite, id_branch;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic [31:0] rsdata, rtdataOrextimm, ex_storedata;
    logic [3:0]  ALUctrl;
    logic [4:0]  ex_writereg;
    logic        ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_branch, ex_illegal;
    logic        load_use_hazard;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rsdata(id_rsdata), .id_rtdata(id_rtdata), .id_signimm(id_signimm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluop(id_aluop), .id_funct(id_funct),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
        .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .rsdata(rsdata), .rtdataOrextimm(rtdataOrextimm), .ALUctrl(ALUctrl),
        .ex_storedata(ex_storedata), .ex_writereg(ex_writereg), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_illegal(ex_illegal), .load_use_hazard(load_use_hazard)
    );

    localparam int S_RS = 0, S_OPB = 1, S_ALU = 2, S_ST = 3, S_WR = 4, S_VLD = 5;
    localparam int S_RW = 6, S_ILL = 7, S_HAZ = 8, S_MW = 9, S_BR = 10, S_MTR = 11;

    string       name_q[$];
    int          sig_q[$];
    logic [31:0] val_q[$];
    int          total  = 0;
    int          passed = 0;

    string       mon_nm;
    int          mon_sig;
    logic [31:0] mon_exp, mon_act;

    task automatic expect_sig(input string nm, input int s, input logic [31:0] v);
        name_q.push_back(nm);
        sig_q.push_back(s);
        val_q.push_back(v);
    endtask

    // Monitor: consume every queued expectation at the negedge
    always @(negedge clk) begin
        while (sig_q.size() > 0) begin
            mon_nm  = name_q.pop_front();
            mon_sig = sig_q.pop_front();
            mon_exp = val_q.pop_front();
            case (mon_sig)
                S_RS:    mon_act = rsdata;
                S_OPB:   mon_act = rtdataOrextimm;
                S_ALU:   mon_act = {28'd0, ALUctrl};
                S_ST:    mon_act = ex_storedata;
                S_WR:    mon_act = {27'd0, ex_writereg};
                S_VLD:   mon_act = {31'd0, ex_valid};
                S_RW:    mon_act = {31'd0, ex_regwrite};
                S_ILL:   mon_act = {31'd0, ex_illegal};
                S_HAZ:   mon_act = {31'd0, load_use_hazard};
                S_MW:    mon_act = {31'd0, ex_memwrite};
                S_BR:    mon_act = {31'd0, ex_branch};
                default: mon_act = {31'd0, ex_memtoreg};
            endcase
            total = total + 1;
            if (mon_act === mon_exp)
                passed = passed + 1;
            else
                $display("FAIL %s: got 0x%08h, want 0x%08h", mon_nm, mon_act, mon_exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic done();
        @(negedge clk);
        #1;
    endtask

    task automatic id_clear();
        id_valid = 1'b0; id_rsdata = 32'd0; id_rtdata = 32'd0; id_signimm = 32'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_aluop = 2'b00; id_funct = 6'd0;
        id_alusrc = 1'b0; id_regdst = 1'b0; id_regwrite = 1'b0; id_memtoreg = 1'b0;
        id_memwrite = 1'b0; id_branch = 1'b0;
    endtask

    task automatic fwd_clear();
        mem_regwrite = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
    endtask

    task automatic set_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
        id_clear();
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd; id_rsdata = a; id_rtdata = b;
        id_aluop = 2'b10; id_funct = f; id_regdst = 1'b1; id_regwrite = 1'b1;
    endtask

    logic [5:0] f_tab [4] = '{6'b100100, 6'b100101, 6'b101010, 6'b100010};
    logic [3:0] a_tab [4] = '{4'b0000, 4'b0001, 4'b0111, 4'b0110};

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, checks %0d/%0d", passed, total);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        id_clear();
        fwd_clear();

        // Reset state
        step(); step();
        expect_sig("rst_rsdata", S_RS, 32'd0);
        expect_sig("rst_opb", S_OPB, 32'd0);
        expect_sig("rst_aluctrl", S_ALU, 32'h2);
        expect_sig("rst_store", S_ST, 32'd0);
        expect_sig("rst_writereg", S_WR, 32'd0);
        expect_sig("rst_valid", S_VLD, 32'd0);
        expect_sig("rst_regwrite", S_RW, 32'd0);
        expect_sig("rst_hazard", S_HAZ, 32'd0);
        done();
        rst_n = 1'b1;

        // First capture: add r3, r1(5), r2(7)
        set_r(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 6'b100000);
        step();
        expect_sig("add_rsdata", S_RS, 32'd5);
        expect_sig("add_opb", S_OPB, 32'd7);
        expect_sig("add_aluctrl", S_ALU, 32'h2);
        expect_sig("add_writereg", S_WR, 32'd3);
        expect_sig("add_valid", S_VLD, 32'd1);
        expect_sig("add_regwrite", S_RW, 32'd1);
        expect_sig("add_illegal", S_ILL, 32'd0);
        done();

        // R-type funct sweep
        for (int i = 0; i < 4; i++) begin
            set_r(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, f_tab[i]);
            step();
            expect_sig("funct_aluctrl", S_ALU, {28'd0, a_tab[i]});
            done();
        end

        // aluop 01 (sub) and 11 (or)
        set_r(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 6'b100100);
        id_aluop = 2'b01;
        step();
        expect_sig("aluop01_aluctrl", S_ALU, 32'h6);
        done();
        id_aluop = 2'b11;
        step();
        expect_sig("aluop11_aluctrl", S_ALU, 32'h1);
        done();

        // Illegal funct: ADD code, flagged, write enables suppressed
        set_r(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 6'b000000);
        id_memwrite = 1'b1;
        step();
        expect_sig("illegal_aluctrl", S_ALU, 32'h2);
        expect_sig("illegal_flag", S_ILL, 32'd1);
        expect_sig("illegal_regwrite", S_RW, 32'd0);
        expect_sig("illegal_memwrite", S_MW, 32'd0);
        done();

        // Forwarding priority on rs = r3, then held by stall while sources change
        id_clear();
        id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd5; id_rsdata = 32'hAA; id_rtdata = 32'hBB;
        id_regwrite = 1'b1;
        step();
        mem_regwrite = 1'b1; mem_rd = 5'd3; mem_result = 32'h11;
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_result = 32'h22;
        stall = 1'b1;
        expect_sig("fwd_mem_rs", S_RS, 32'h11);
        expect_sig("fwd_none_rt", S_OPB, 32'hBB);
        expect_sig("fwd_writereg_rt", S_WR, 32'd5);
        done();
        step();
        mem_regwrite = 1'b0;
        expect_sig("fwd_wb_rs", S_RS, 32'h22);
        done();
        step();
        wb_rd = 5'd5; wb_result = 32'h33;
        expect_sig("fwd_reg_rs", S_RS, 32'hAA);
        expect_sig("fwd_wb_rt_opb", S_OPB, 32'h33);
        expect_sig("fwd_wb_rt_store", S_ST, 32'h33);
        done();
        stall = 1'b0;

        // Register 0 is never forwarded
        id_clear();
        id_valid = 1'b1; id_rsdata = 32'h44; id_rtdata = 32'h55;
        mem_regwrite = 1'b1; mem_rd = 5'd0; mem_result = 32'h11;
        wb_regwrite = 1'b1; wb_rd = 5'd0; wb_result = 32'h22;
        step();
        expect_sig("r0_rsdata", S_RS, 32'h44);
        expect_sig("r0_opb", S_OPB, 32'h55);
        expect_sig("r0_store", S_ST, 32'h55);
        done();

        // Immediate select with a forwarded store value
        id_clear();
        id_valid = 1'b1; id_rt = 5'd6; id_alusrc = 1'b1; id_signimm = 32'hFFFF_FFFC;
        id_memwrite = 1'b1;
        fwd_clear();
        wb_regwrite = 1'b1; wb_rd = 5'd6; wb_result = 32'h9;
        step();
        expect_sig("imm_opb", S_OPB, 32'hFFFF_FFFC);
        expect_sig("imm_store", S_ST, 32'h9);
        expect_sig("imm_memwrite", S_MW, 32'd1);
        done();

        // Load-use: lw r4 in EX, dependent add reads r4
        fwd_clear();
        id_clear();
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd4; id_rsdata = 32'h100; id_signimm = 32'd8;
        id_alusrc = 1'b1; id_memtoreg = 1'b1; id_regwrite = 1'b1;
        step();
        set_r(5'd4, 5'd2, 5'd5, 32'hDEAD, 32'd7, 6'b100000);
        expect_sig("lw_writereg", S_WR, 32'd4);
        expect_sig("lw_memtoreg", S_MTR, 32'd1);
        expect_sig("lw_opb_imm", S_OPB, 32'd8);
        expect_sig("lu_hazard", S_HAZ, 32'd1);
        done();
        step();
        mem_regwrite = 1'b1; mem_rd = 5'd4; mem_result = 32'h1234;
        expect_sig("lu_bubble_valid", S_VLD, 32'd0);
        expect_sig("lu_bubble_regwrite", S_RW, 32'd0);
        expect_sig("lu_hazard_clear", S_HAZ, 32'd0);
        done();
        mem_regwrite = 1'b0;
        wb_regwrite = 1'b1; wb_rd = 5'd4; wb_result = 32'h5555;
        step();
        expect_sig("lu_dep_rs_wb", S_RS, 32'h5555);
        expect_sig("lu_dep_opb", S_OPB, 32'd7);
        expect_sig("lu_dep_valid", S_VLD, 32'd1);
        expect_sig("lu_dep_writereg", S_WR, 32'd5);
        expect_sig("lu_dep_hazard", S_HAZ, 32'd0);
        done();

        // Stall for 3 cycles, then stall+flush
        fwd_clear();
        id_clear();
        id_valid = 1'b1; id_rs = 5'd7; id_rt = 5'd8; id_rd = 5'd9; id_rsdata = 32'h70;
        id_rtdata = 32'h80; id_aluop = 2'b11; id_regdst = 1'b1; id_regwrite = 1'b1;
        id_branch = 1'b1;
        step();
        expect_sig("pre_stall_rs", S_RS, 32'h70);
        expect_sig("pre_stall_branch", S_BR, 32'd1);
        done();
        stall = 1'b1;
        set_r(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 6'b100010);
        for (int k = 0; k < 3; k++) begin
            step();
            expect_sig("stall_rs", S_RS, 32'h70);
            expect_sig("stall_opb", S_OPB, 32'h80);
            expect_sig("stall_aluctrl", S_ALU, 32'h1);
            expect_sig("stall_writereg", S_WR, 32'd9);
            expect_sig("stall_valid", S_VLD, 32'd1);
            done();
        end
        flush = 1'b1;
        step();
        expect_sig("flush_valid", S_VLD, 32'd0);
        expect_sig("flush_regwrite", S_RW, 32'd0);
        expect_sig("flush_aluctrl", S_ALU, 32'h2);
        expect_sig("flush_rs", S_RS, 32'd0);
        expect_sig("flush_writereg", S_WR, 32'd0);
        expect_sig("flush_branch", S_BR, 32'd0);
        done();
        stall = 1'b0; flush = 1'b0;
        step();
        expect_sig("post_stall_rs", S_RS, 32'd5);
        expect_sig("post_stall_aluctrl", S_ALU, 32'h6);
        expect_sig("post_stall_valid", S_VLD, 32'd1);
        done();

        // Asynchronous reset in the middle of a stall
        stall = 1'b1;
        rst_n = 1'b0;
        #1;
        expect_sig("midrst_valid", S_VLD, 32'd0);
        expect_sig("midrst_rs", S_RS, 32'd0);
        expect_sig("midrst_aluctrl", S_ALU, 32'h2);
        expect_sig("midrst_writereg", S_WR, 32'd0);
        done();
        rst_n = 1'b1; stall = 1'b0;
        step();
        expect_sig("after_rst_rs", S_RS, 32'd5);
        expect_sig("after_rst_valid", S_VLD, 32'd1);
        done();

        if (sig_q.size() != 0) begin
            total = total + 1;
            $display("FAIL drain: got %0d pending, want 0", sig_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
